// File: rtl/bitstream_pc_ctrl.sv
// Read-pointer / fill-level controller for the circular bitstream window.
// Tracks the parser bit pointer, buffered bit count and the refill word address.
module bitstream_pc_ctrl #(
  parameter int unsigned PC_W   = 7,
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned NSRC   = 4,
  parameter int unsigned WORD_W = 16,
  localparam int unsigned SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int unsigned WB    = $clog2(WORD_W),
  localparam int unsigned WA_W  = PC_W - WB
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    adv_valid_i,
  input  logic [2:0]              adv_mode_i,
  input  logic [SRC_W-1:0]        adv_src_i,
  input  logic [NSRC*LEN_W-1:0]   len_bus_i,
  input  logic [LEN_W-1:0]        fixed_len_i,
  output logic                    adv_ready_o,
  output logic [PC_W-1:0]         pc_o,
  output logic [PC_W-1:0]         pc_next_o,
  output logic [PC_W:0]           level_o,
  input  logic                    refill_valid_i,
  output logic                    refill_ready_o,
  output logic [WA_W-1:0]         wr_addr_o,
  output logic                    err_mode_o
);

  localparam int unsigned DEPTH = 2 ** PC_W;
  localparam int unsigned LW    = PC_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W:0]    level_q, level_d;
  logic [WA_W-1:0]  wr_addr_q, wr_addr_d;
  logic             err_q, err_d;

  logic [LEN_W-1:0] src_len [NSRC];
  logic [PC_W:0]    req;
  logic             mode_legal;
  logic [2:0]       byte_gap;
  logic [WB-1:0]    word_gap;
  logic             advance;
  logic             refill_fire;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign src_len[k] = len_bus_i[k*LEN_W +: LEN_W];
  end

  // Distance to the next byte / word boundary; zero when already aligned.
  assign byte_gap = 3'd0 - pc_q[2:0];
  assign word_gap = WB'(0) - pc_q[WB-1:0];

  always_comb begin
    req        = '0;
    mode_legal = 1'b1;
    case (adv_mode_i)
      3'd0:    req = '0;
      3'd1:    req = LW'(fixed_len_i);
      3'd2:    req = LW'(src_len[adv_src_i]);
      3'd3:    req = LW'(byte_gap);
      3'd4:    req = LW'(word_gap);
      default: mode_legal = 1'b0;
    endcase
  end

  assign adv_ready_o    = reset_n & ~flush_i & adv_valid_i & (req <= level_q);
  assign refill_ready_o = reset_n & ~flush_i & (level_q <= LW'(DEPTH - WORD_W));
  assign advance        = adv_ready_o & mode_legal;
  assign refill_fire    = refill_valid_i & refill_ready_o;

  always_comb begin
    pc_d      = advance ? pc_q + req[PC_W-1:0] : pc_q;
    level_d   = level_q - (advance ? req : '0) + (refill_fire ? LW'(WORD_W) : '0);
    wr_addr_d = refill_fire ? wr_addr_q + 1'b1 : wr_addr_q;
    // Illegal modes are acknowledged so the parser never deadlocks, but flagged.
    err_d     = err_q | (adv_ready_o & ~mode_legal);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q      <= '0;
      level_q   <= '0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else if (flush_i) begin
      pc_q      <= '0;
      level_q   <= '0;
      wr_addr_q <= '0;
    end else begin
      pc_q      <= pc_d;
      level_q   <= level_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_next_o  = pc_d;
  assign level_o    = level_q;
  assign wr_addr_o  = wr_addr_q;
  assign err_mode_o = err_q;

endmodule
